fifo_rd_drain: RTL and testbench

- Read-side engine for the team's FIFOs, in the rd_clk domain.
- Issues rd_en to a FIFO read port (registered rdata, 1-cycle read latency) and presents the words on a valid/ready stream.
- A 2-entry output buffer absorbs the read latency, so full throughput (1 word/cycle) holds under continuous m_ready.
- Counts delivered words.

---
 rtl/fifo_rd_drain.sv | 123 ++++++++++++
 tb/tb_fifo_rd_drain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: issues FIFO reads and presents words on a valid/ready stream.
// Optional burst framing (m_last, burst-aligned flush) is enabled by FIFO_RD_DRAIN_BURST_EN.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
`ifdef FIFO_RD_DRAIN_BURST_EN
  output logic                  m_last,
`endif
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("BURST_LEN must be >= 1");
  end

  logic [1:0]            state, state_nxt;
  logic [1:0]            occ;
  logic                  pending;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic [2:0]            outstanding_after;
  logic                  flush_ok;

  assign pop               = m_valid & m_ready;
  assign m_valid           = (occ != 2'd0);
  assign m_data            = head;
  assign busy              = (state != IDLE);
  assign occ_after_pop     = occ - {1'b0, pop};
  // Buffered plus in-flight words after this cycle's pop must leave room for one more.
  assign outstanding_after = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign fifo_rd_en        = (state == RUN) & ~fifo_empty & (outstanding_after < 3'd2);

`ifdef FIFO_RD_DRAIN_BURST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

  logic [BW-1:0] beat, beat_nxt;

  always_comb begin
    beat_nxt = beat;
    if (pop) beat_nxt = (beat == BEAT_MAX) ? '0 : beat + 1'b1;
  end

  assign m_last   = m_valid & (beat == BEAT_MAX);
  // Leaving RUN is deferred to a burst boundary unless the FIFO has run dry.
  assign flush_ok = (beat_nxt == '0) | fifo_empty;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) beat <= '0;
    else     beat <= beat_nxt;
  end
`else
  assign flush_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable && flush_ok) state_nxt = FLUSH;
      FLUSH: begin
        if (enable)                                   state_nxt = RUN;
        else if (!pending && (occ_after_pop == 2'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      occ      <= 2'd0;
      pending  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      xfer_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pending <= fifo_rd_en;
      // Two-entry shift buffer: head feeds m_data, tail holds the next word.
      case ({pending, pop})
        2'b10: begin
          if (occ == 2'd0) head <= fifo_rdata;
          else             tail <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          tail <= '0;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= fifo_rdata;
          end else begin
            head <= fifo_rdata;
          end
        end
        default: ;
      endcase
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: a FIFO model feeds the DUT, a scoreboard checks every beat.
// Build with FIFO_RD_DRAIN_BURST_EN defined to also check m_last and burst-aligned flush.
`define CHK(got, want, tag) \
  begin \
    tests++; \
    assert ((got) === (want)) else begin \
      fails++; \
      $error("FAIL %s: got %0h want %0h", tag, (got), (want)); \
    end \
  end

module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int BL = 4;
`ifdef FIFO_RD_DRAIN_BURST_EN
  localparam int FLUSH_MAX = BL + 1;
`else
  localparam int FLUSH_MAX = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty, fifo_rd_en, m_valid, busy;
  logic [DW-1:0] fifo_rdata = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_cnt;
`ifdef FIFO_RD_DRAIN_BURST_EN
  logic          m_last;
`endif

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL)) dut (
    .rd_clk     (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
`ifdef FIFO_RD_DRAIN_BURST_EN
    .m_last     (m_last),
`endif
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO model: registered read data, one cycle after an accepted rd_en.
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  // Words requested but not yet handed downstream (buffered + in flight).
  int outstanding = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) outstanding <= 0;
    else     outstanding <= outstanding + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
  end

  logic [DW-1:0] exp_q [$];
  int            beats = 0;
  int            total_pops = 0;
  logic          hold_chk = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW-1:0] want_word;

  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
      beats    = 0;
    end else begin
      if (hold_chk) begin
        `CHK(m_valid, 1'b1, "hold_valid")
        `CHK(m_data, held, "hold_data")
      end
      if (fifo_rd_en) begin
        `CHK(fifo_empty, 1'b0, "rd_when_empty")
        `CHK((outstanding - ((m_valid && m_ready) ? 1 : 0)) < 2, 1'b1, "rd_en_limit")
      end
      `CHK(outstanding <= 2, 1'b1, "occ_max")
      if (m_valid && m_ready) begin
        beats++;
        total_pops++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL extra_beat: got %0h want no beat", m_data);
        end
        if (exp_q.size() != 0) begin
          want_word = exp_q.pop_front();
          `CHK(m_data, want_word, "beat_data")
        end
`ifdef FIFO_RD_DRAIN_BURST_EN
        `CHK(m_last, ((beats % BL) == 0), "m_last")
`endif
      end
      hold_chk = m_valid && !m_ready;
      held     = m_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    `CHK(exp_q.size(), 0, tag)
    cyc(1);
  endtask

  task automatic go_idle(input string tag);
    int n = 0;
    enable = 1'b0;
    while (busy && n < 20) begin
      cyc(1);
      n++;
    end
    `CHK(busy, 1'b0, tag)
    `CHK(m_valid, 1'b0, tag)
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 20) begin
      cyc(1);
      n++;
    end
  endtask

  int n, delivered, left;

  initial begin
    // Reset state
    cyc(2);
    `CHK(m_valid, 1'b0, "rst_valid")
    `CHK(fifo_rd_en, 1'b0, "rst_rd_en")
    `CHK(busy, 1'b0, "rst_busy")
    `CHK(m_data, 8'h00, "rst_data")
    `CHK(xfer_cnt, 4'h0, "rst_cnt")
    rst = 1'b0;
    cyc(1);

    // Empty gaps: one word every 5 cycles
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(8'hA0 + 8'(i));
      cyc(5);
    end
    wait_drain(20, "gaps_drain");
    `CHK(xfer_cnt, 4'd4, "gaps_cnt")
    go_idle("gaps_idle");

    // Reset mid-stream with a full buffer
    m_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    enable = 1'b1;
    cyc(8);
    `CHK(m_valid, 1'b1, "pre_rst_valid")
    `CHK(fifo_rd_en, 1'b0, "pre_rst_rd_en")
    rst = 1'b1;
    enable = 1'b0;
    #1;
    `CHK(m_valid, 1'b0, "async_rst_valid")
    `CHK(xfer_cnt, 4'h0, "async_rst_cnt")
    `CHK(fifo_rd_en, 1'b0, "async_rst_rd_en")
    `CHK(busy, 1'b0, "async_rst_busy")
    `CHK(m_data, 8'h00, "async_rst_data")
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    cyc(2);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      `CHK(m_valid, 1'b0, "no_beat_disabled")
    end
    enable = 1'b1;
    wait_drain(20, "post_rst_drain");
    `CHK(xfer_cnt, 4'd2, "post_rst_cnt")
    go_idle("post_rst_idle");

    // Streaming 16 words at full rate
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    enable = 1'b1;
    wait_valid(n);
    `CHK(n, 3, "first_latency")
    for (int i = 0; i < 16; i++) begin
      `CHK(m_valid, 1'b1, "stream_valid")
      cyc(1);
    end
    `CHK(exp_q.size(), 0, "stream_left")
    `CHK(xfer_cnt, 4'd2, "stream_cnt")
    go_idle("stream_idle");

    // Backpressure: m_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) push_word(8'h81 + 8'(i));
    enable = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      m_ready = ((i % 4) == 0) || ((i % 4) == 3);
      cyc(1);
    end
    `CHK(exp_q.size(), 0, "bp_drain")
    cyc(1);
    m_ready = 1'b1;
    `CHK(xfer_cnt, 4'd10, "bp_cnt")
    go_idle("bp_idle");

    // Flush: drop enable in the cycle the third beat is taken
    for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
    delivered = total_pops;
    enable = 1'b1;
    wait_valid(n);
    `CHK(n, 3, "flush_latency")
    cyc(2);
    enable = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      cyc(1);
      n++;
    end
    `CHK(busy, 1'b0, "flush_idle")
    `CHK(m_valid, 1'b0, "flush_valid")
    delivered = total_pops - delivered;
    `CHK((delivered >= 3) && (delivered <= 3 + FLUSH_MAX), 1'b1, "flush_extra")
    left = int'(8'(wr_ptr - rd_ptr));
    `CHK(left, 8 - delivered, "flush_left")
    `CHK(xfer_cnt, CW'(10 + delivered), "flush_cnt")
    exp_q.delete();
    wr_ptr = rd_ptr;

    // Counter wrap: 17 beats from reset
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) push_word(8'h30 + 8'(i));
    enable = 1'b1;
    wait_drain(60, "wrap_drain");
    `CHK(xfer_cnt, 4'd1, "wrap_cnt")
    go_idle("wrap_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: got no finish want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
